// File: rtl/wb_lsu_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_lsu_master_pkg
// Shared definitions for the load/store Wishbone initiator:
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - byte-lane geometry
//   - helpers for funct3 legality and natural-alignment checks
// -----------------------------------------------------------------------------
package wb_lsu_master_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    if (store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // f3[1:0] gives the access size for both loads and stores: 00 byte,
  // 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_lsu_master_lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for a 32-bit data port.
//   funct3_i  access type (size in [1:0], unsigned load in [2])
//   store_i   1 = store, 0 = load
//   off_i     byte offset within the word (addr[1:0])
//   wdata_i   unshifted store data (rs2)
//   rdata_i   raw bus read data
//   sel_o     byte strobes (all lanes for loads)
//   wdata_o   store data replicated onto every lane it may occupy
//   rdata_o   selected and sign/zero-extended load data
// -----------------------------------------------------------------------------
module lsu_lane_align
  import wb_lsu_master_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [LANE_W-1:0] lane_bytes [NUM_LANES];
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lanes
      assign lane_bytes[gi] = rdata_i[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign byte_sel = lane_bytes[off_i];
  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = 32'h0;
    if (store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          sel_o   = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          sel_o   = 4'b0011 << off_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          sel_o   = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    case (funct3_i)
      F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  rdata_o = {24'h0, byte_sel};
      F3_LHU:  rdata_o = {16'h0, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// -----------------------------------------------------------------------------
// wb_lsu_master
// Single-outstanding load/store initiator on a pipelined Wishbone data port.
//   clk, rst (async, active-low)
//   req_*   pipeline request (req_ready high only while idle)
//   flush   abandons an access that is on the bus; no response is produced
//   resp_*  one-cycle completion pulse with extended load data / fault flags
//   wb_*    Wishbone initiator signals (cyc/stb/wr_en/addr/wr_data/wr_sel,
//           ack/stall/rd_data)
// Illegal funct3 and misaligned accesses are answered without touching the bus.
// Optional: define LSU_TIMEOUT_EN to abort a bus access that has not been
// acknowledged after TIMEOUT_CYCLES cycles in one bus state (resp_err=1).
// -----------------------------------------------------------------------------
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_wr_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_wr_data,
  output logic [3:0]        wb_wr_sel,
  input  logic              wb_ack,
  input  logic              wb_stall,
  input  logic [31:0]       wb_rd_data
);

  lsu_state_e        state_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_ready_q, cyc_q, stb_q, we_q;
  logic [31:0]       wr_data_q;
  logic [3:0]        sel_q;
  logic              resp_valid_q, resp_mis_q, resp_err_q;
  logic [31:0]       resp_rdata_q;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
`endif

  // While idle the aligner sees the incoming request (store lane steering);
  // afterwards it sees the captured request (load extension on ack).
  logic        idle;
  logic [2:0]  al_funct3;
  logic        al_store;
  logic [1:0]  al_off;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata, al_rdata;

  assign idle      = (state_q == ST_IDLE);
  assign al_funct3 = idle ? req_funct3    : funct3_q;
  assign al_store  = idle ? req_store     : store_q;
  assign al_off    = idle ? req_addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .funct3_i (al_funct3),
    .store_i  (al_store),
    .off_i    (al_off),
    .wdata_i  (req_wdata),
    .rdata_i  (wb_rd_data),
    .sel_o    (al_sel),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      req_ready_q  <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      wr_data_q    <= 32'h0;
      sel_q        <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_mis_q   <= 1'b0;
      resp_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= 16'h0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Any ack seen here belongs to a flushed access and is ignored.
          if (req_valid) begin
            store_q     <= req_store;
            funct3_q    <= req_funct3;
            addr_q      <= req_addr;
            req_ready_q <= 1'b0;
            if (!funct3_legal(req_store, req_funct3)) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_mis_q   <= 1'b1;
            end else begin
              state_q   <= ST_REQ;
              cyc_q     <= 1'b1;
              stb_q     <= 1'b1;
              we_q      <= req_store;
              sel_q     <= al_sel;
              wr_data_q <= al_wdata;
`ifdef LSU_TIMEOUT_EN
              cnt_q     <= 16'h0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (flush) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            req_ready_q <= 1'b1;
          end else if (!wb_stall) begin
            stb_q <= 1'b0;
            if (wb_ack) begin
              state_q      <= ST_RESP;
              cyc_q        <= 1'b0;
              we_q         <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= store_q ? 32'h0 : al_rdata;
            end else begin
              state_q <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
              cnt_q   <= 16'h0;
`endif
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == TO_LIMIT) begin
            state_q      <= ST_RESP;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
`endif
        end
        ST_WAIT: begin
          if (flush) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            req_ready_q <= 1'b1;
          end else if (wb_ack) begin
            state_q      <= ST_RESP;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= store_q ? 32'h0 : al_rdata;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == TO_LIMIT) begin
            state_q      <= ST_RESP;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
`endif
        end
        ST_RESP: begin
          // Response fields read as zero whenever resp_valid is low.
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_rdata_q <= 32'h0;
          resp_mis_q   <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_err        = resp_err_q;
  assign wb_cyc          = cyc_q;
  assign wb_stb          = stb_q;
  assign wb_wr_en        = we_q;
  assign wb_addr         = addr_q;
  assign wb_wr_data      = wr_data_q;
  assign wb_wr_sel       = sel_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// -----------------------------------------------------------------------------
// tb_wb_lsu_master
// Directed load/store vectors against wb_lsu_master. The driver plays the
// Wishbone target and pushes the expected response into a queue; a monitor
// pops and compares on every resp_valid. Define LSU_TIMEOUT_EN for both the
// DUT and this bench to include the bus-timeout vector.
// -----------------------------------------------------------------------------
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_misaligned, resp_err;
  logic [31:0] resp_rdata;
  logic        wb_cyc, wb_stb, wb_wr_en;
  logic [31:0] wb_addr, wb_wr_data, wb_rd_data;
  logic [3:0]  wb_wr_sel;
  logic        wb_ack, wb_stall;

  wb_lsu_master #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .flush           (flush),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_err        (resp_err),
    .wb_cyc          (wb_cyc),
    .wb_stb          (wb_stb),
    .wb_wr_en        (wb_wr_en),
    .wb_addr         (wb_addr),
    .wb_wr_data      (wb_wr_data),
    .wb_wr_sel       (wb_wr_sel),
    .wb_ack          (wb_ack),
    .wb_stall        (wb_stall),
    .wb_rd_data      (wb_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          lat;   // clock edges from acceptance to resp_valid; -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  int   accept_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("RESP rdata=0x%08h err=%0b mis=%0b lat=%0d", resp_rdata, resp_err,
                 resp_misaligned, cyc_cnt - accept_cyc);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, e.mis});
        if (e.lat >= 0) chk("resp_latency", cyc_cnt - accept_cyc, e.lat);
      end
    end
  end

  // ack_dly: 0 = ack with the first unstalled strobe, n>0 = ack n cycles later,
  // -1 = never ack.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input int stall_n,
                     input int ack_dly, input logic [31:0] e_rdata, input logic e_err,
                     input logic e_mis, input logic [3:0] e_sel, input logic [31:0] e_wd,
                     input int e_lat);
    exp_t e;
    int   n;
    chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
    e.rdata = e_rdata; e.err = e_err; e.mis = e_mis; e.lat = e_lat;
    exp_q.push_back(e);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    tick();
    accept_cyc = cyc_cnt;
    req_valid = 1'b0;
    if (e_err || e_mis) begin
      chk("fault_no_cyc", {31'h0, wb_cyc}, 32'd0);
    end else begin
      chk("req_ready_busy", {31'h0, req_ready}, 32'd0);
      chk("cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'd3);
      chk("wb_addr", wb_addr, addr);
      chk("wb_wr_sel", {28'h0, wb_wr_sel}, {28'h0, e_sel});
      chk("wb_wr_en", {31'h0, wb_wr_en}, {31'h0, st});
      if (st) chk("wb_wr_data", wb_wr_data, e_wd);
      for (int i = 0; i < stall_n; i++) begin
        wb_stall = 1'b1;
        tick();
        chk("stall_stb_held", {30'h0, wb_cyc, wb_stb}, 32'd3);
        chk("stall_addr", wb_addr, addr);
        chk("stall_sel", {28'h0, wb_wr_sel}, {28'h0, e_sel});
        if (st) chk("stall_data", wb_wr_data, e_wd);
      end
      wb_stall = 1'b0;
      wb_rd_data = rd;
      if (ack_dly == 0) begin
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("cyc_drop", {31'h0, wb_cyc}, 32'd0);
      end else begin
        tick();
        chk("wait_cyc_only", {30'h0, wb_cyc, wb_stb}, 32'd2);
        if (ack_dly > 0) begin
          repeat (ack_dly - 1) tick();
          wb_ack = 1'b1;
          tick();
          wb_ack = 1'b0;
          chk("cyc_drop", {31'h0, wb_cyc}, 32'd0);
        end
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    chk("cyc_idle_after", {31'h0, wb_cyc}, 32'd0);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
    req_wdata = 32'h0; flush = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0; wb_rd_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_cyc_stb_we", {29'h0, wb_cyc, wb_stb, wb_wr_en}, 32'd0);
    chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'd0);
    chk("rst_sel", {28'h0, wb_wr_sel}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    //   st    f3      addr          wdata         rd_data      stl ack  exp_rdata     err   mis   sel      exp_wdata     lat
    txn(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 1, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 2);
    txn(1'b1, 3'b010, 32'h0000_0014, 32'h1234_5678, 32'h0,        0, 0, 32'h0,        1'b0, 1'b0, 4'b1111, 32'h1234_5678, 1);
    txn(1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'h80FF_0000, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b1111, 32'h0,        1);
    txn(1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'h80FF_0000, 0, 1, 32'h0000_0080, 1'b0, 1'b0, 4'b1111, 32'h0,        2);
    txn(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 32'h0,        3, 1, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 5);
    txn(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,        0, 0, 32'h0,        1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 1);
    txn(1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_1234, 0, 0, 32'hFFFF_8001, 1'b0, 1'b0, 4'b1111, 32'h0,        1);
    txn(1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_1234, 0, 2, 32'h0000_8001, 1'b0, 1'b0, 4'b1111, 32'h0,        3);
    txn(1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'hFFFF_7FFF, 0, 0, 32'h0000_7FFF, 1'b0, 1'b0, 4'b1111, 32'h0,        1);
    txn(1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b1111, 32'h0,        2);
    txn(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0,       -1);
    txn(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0,       -1);
    txn(1'b1, 3'b010, 32'h0000_0006, 32'h1111_2222, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0,       -1);
    txn(1'b1, 3'b011, 32'h0000_0008, 32'h1111_2222, 32'h0,        0, 0, 32'h0,        1'b1, 1'b0, 4'b1111, 32'h0,       -1);
    txn(1'b0, 3'b110, 32'h0000_0008, 32'h0,        32'h0,        0, 0, 32'h0,        1'b1, 1'b0, 4'b1111, 32'h0,       -1);

    // Flush while waiting for ack; the late ack must be ignored.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    tick();
    req_valid = 1'b0;
    chk("flush_cyc_up", {30'h0, wb_cyc, wb_stb}, 32'd3);
    tick();
    chk("flush_in_wait", {30'h0, wb_cyc, wb_stb}, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_bus_drop", {30'h0, wb_cyc, wb_stb}, 32'd0);
    chk("flush_ready", {31'h0, req_ready}, 32'd1);
    wb_ack = 1'b1; wb_rd_data = 32'h5555_5555;
    tick();
    wb_ack = 1'b0;
    chk("late_ack_ready", {31'h0, req_ready}, 32'd1);
    chk("late_ack_no_cyc", {31'h0, wb_cyc}, 32'd0);
    tick();
    txn(1'b0, 3'b010, 32'h0000_0084, 32'h0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 4'b1111, 32'h0, 2);

`ifdef LSU_TIMEOUT_EN
    txn(1'b0, 3'b010, 32'h0000_0090, 32'h0, 32'h0, 0, -1, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, 5);
`endif

    // Asynchronous reset in the middle of a stalled strobe.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'hA0;
    req_wdata = 32'h7777_7777;
    tick();
    req_valid = 1'b0;
    wb_stall = 1'b1;
    chk("areset_pre_cyc", {30'h0, wb_cyc, wb_stb}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_bus_drop", {30'h0, wb_cyc, wb_stb}, 32'd0);
    chk("areset_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    wb_stall = 1'b0;
    tick();
    txn(1'b1, 3'b001, 32'h0000_0030, 32'h0000_1357, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 4'b0011, 32'h1357_1357, 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
